// File: rtl/ad_usb_stream.sv
// ad_usb_stream
// Drain stage between the ping-pong ADC cache and a slave-FIFO USB bridge.
// It runs in the cache read clock domain. Each toggle of `switch` marks one
// ready half-buffer. The block then reads exactly BLK_WORDS words with `rd`
// strobes and forwards them with slwr-style writes. A skid FIFO absorbs the
// cache read latency, so a full USB FIFO never causes a lost word.
//
// Ports:
//   clk           block clock (cache read clock)
//   rst           synchronous, active-high reset
//   en            enables block starts
//   switch        half-buffer ready toggle from the cache
//   rd            cache read strobe, one word per high cycle
//   rdata         cache read data, valid RD_LAT cycles after rd
//   usb_full_n    USB FIFO full flag, active low
//   usb_slwr_n    USB write strobe, active low
//   usb_data      USB write data
//   usb_pktend_n  USB packet-end strobe, active low
//   busy          high while a block is in progress
//   overrun       sticky; a switch edge arrived while busy
//
// Optional feature: define AD_USB_PKTEND_EN to emit one usb_pktend_n pulse
// at the end of each block. Without it, usb_pktend_n is tied high.
module ad_usb_stream #(
  parameter int DATA_NBIT  = 16,
  parameter int BLK_WORDS  = 3072,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 switch,
  output logic                 rd,
  input  logic [DATA_NBIT-1:0] rdata,
  input  logic                 usb_full_n,
  output logic                 usb_slwr_n,
  output logic [DATA_NBIT-1:0] usb_data,
  output logic                 usb_pktend_n,
  output logic                 busy,
  output logic                 overrun
);

  localparam int IW = $clog2(BLK_WORDS + 1);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = $clog2(SKID_DEPTH);
  // Wide enough for fifo_cnt + every read in flight + the strobe now on rd.
  localparam int SW = $clog2(SKID_DEPTH + RD_LAT + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_END   = 2'd3
  } state_t;

  function automatic logic [SW-1:0] popcount(input logic [RD_LAT-1:0] v);
    logic [SW-1:0] c;
    c = {SW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      c = c + SW'(v[i]);
    end
    return c;
  endfunction

  state_t                state_r, state_nx_s;
  logic                  sw_d_r;
  logic                  edge_s;
  logic [IW-1:0]         issued_r;
  logic [RD_LAT-1:0]     infl_r;
  logic [DATA_NBIT-1:0]  mem_r [SKID_DEPTH];
  logic [PW-1:0]         wptr_r, rptr_r;
  logic [CW-1:0]         fifo_cnt_r;
  logic                  rd_r, slwr_n_r, busy_r, overrun_r;
  logic [DATA_NBIT-1:0]  usb_data_r;
  logic                  push_s, pop_s, avail_s, credit_ok_s, drain_done_s;
  logic [DATA_NBIT-1:0]  head_s;
  logic [SW-1:0]         outstanding_s;
  logic                  rd_nx_s, busy_nx_s, overrun_nx_s;
`ifdef AD_USB_PKTEND_EN
  logic                  pktend_n_r, pkt_sent_r, pkt_fire_s;
`endif

  assign edge_s = switch ^ sw_d_r;

  // The oldest in-flight read lands this cycle. When the FIFO is empty, the
  // head bypasses to rdata, so a word can be written the cycle after it arrives.
  assign push_s  = infl_r[RD_LAT-1];
  assign avail_s = (fifo_cnt_r != {CW{1'b0}}) || push_s;
  assign pop_s   = avail_s && usb_full_n;
  assign head_s  = (fifo_cnt_r != {CW{1'b0}}) ? mem_r[rptr_r] : rdata;

  // rd_r counts as in flight. Every read ever issued therefore has a
  // reserved FIFO slot, which keeps backpressure from dropping a word.
  assign outstanding_s = SW'(fifo_cnt_r) + popcount(infl_r) + SW'(rd_r);
  assign credit_ok_s   = outstanding_s < SW'(SKID_DEPTH);
  assign drain_done_s  = (infl_r == {RD_LAT{1'b0}}) && !rd_r &&
                         (fifo_cnt_r == {CW{1'b0}});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (edge_s && en) begin
          state_nx_s = ST_READ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issued_r == IW'(BLK_WORDS)) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_nx_s = ST_END;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_END: begin
`ifdef AD_USB_PKTEND_EN
        // Stay until the packet-end pulse is out. It may be stalled by full.
        if (pkt_sent_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_END;
        end
`else
        state_nx_s = ST_IDLE;
`endif
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    rd_nx_s      = (state_r == ST_READ) && (issued_r < IW'(BLK_WORDS)) &&
                   credit_ok_s;
    busy_nx_s    = (state_nx_s != ST_IDLE);
    // A late edge only flags. It is never queued as a new block.
    overrun_nx_s = overrun_r | (edge_s & busy_r);
`ifdef AD_USB_PKTEND_EN
    // Fire on the DRAIN->END transition, or later in END if full held it off.
    pkt_fire_s   = usb_full_n && !pkt_sent_r &&
                   (((state_r == ST_DRAIN) && drain_done_s) ||
                    (state_r == ST_END));
`endif
  end

  // Edge detect, read issue counter and read-latency shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_d_r   <= switch;
      issued_r <= {IW{1'b0}};
      infl_r   <= {RD_LAT{1'b0}};
    end else begin
      sw_d_r <= switch;
      if ((state_r == ST_IDLE) && (state_nx_s == ST_READ)) begin
        issued_r <= {IW{1'b0}};
      end else if (rd_nx_s) begin
        issued_r <= issued_r + IW'(1);
      end else begin
        issued_r <= issued_r;
      end
      infl_r[0] <= rd_r;
      for (int i = 1; i < RD_LAT; i++) begin
        infl_r[i] <= infl_r[i-1];
      end
    end
  end

  // Skid FIFO storage. The contents need no reset; fifo_cnt_r qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= rdata;
    end
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r     <= {PW{1'b0}};
      rptr_r     <= {PW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r       <= 1'b0;
      slwr_n_r   <= 1'b1;
      usb_data_r <= {DATA_NBIT{1'b0}};
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
`ifdef AD_USB_PKTEND_EN
      pktend_n_r <= 1'b1;
      pkt_sent_r <= 1'b0;
`endif
    end else begin
      rd_r      <= rd_nx_s;
      slwr_n_r  <= !pop_s;
      busy_r    <= busy_nx_s;
      overrun_r <= overrun_nx_s;
      if (pop_s) begin
        usb_data_r <= head_s;
      end
`ifdef AD_USB_PKTEND_EN
      pktend_n_r <= !pkt_fire_s;
      if (state_r == ST_IDLE) begin
        pkt_sent_r <= 1'b0;
      end else if (pkt_fire_s) begin
        pkt_sent_r <= 1'b1;
      end
`endif
    end
  end

  assign rd         = rd_r;
  assign usb_slwr_n = slwr_n_r;
  assign usb_data   = usb_data_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
`ifdef AD_USB_PKTEND_EN
  assign usb_pktend_n = pktend_n_r;
`else
  assign usb_pktend_n = 1'b1;
`endif

endmodule

// File: tb/tb_ad_usb_stream.sv
module tb_ad_usb_stream;

  localparam int BLK = 8;
  localparam int LAT = 2;
  localparam int SKD = 4;
`ifdef AD_USB_PKTEND_EN
  localparam int PK_EXP = 1;
`else
  localparam int PK_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, switch, usb_full_n;
  logic        rd, usb_slwr_n, usb_pktend_n, busy, overrun;
  logic [15:0] rdata = 16'h0;
  logic [15:0] usb_data;

  int n_vec = 0, n_err = 0;
  int rd_cnt = 0, wr_cnt = 0, pk_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cache_base = 16'h0;
  logic [15:0] p1 = 16'h0;
  int cache_idx = 0;

  ad_usb_stream #(.DATA_NBIT(16), .BLK_WORDS(BLK), .RD_LAT(LAT), .SKID_DEPTH(SKD)) dut (
    .clk(clk), .rst(rst), .en(en), .switch(switch), .rd(rd), .rdata(rdata),
    .usb_full_n(usb_full_n), .usb_slwr_n(usb_slwr_n), .usb_data(usb_data),
    .usb_pktend_n(usb_pktend_n), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout required completion", name);
  endtask

  // Cache model: the word for the k-th rd of a block is base+k+1, returned LAT=2 cycles later
  always @(posedge clk) begin
    rdata <= p1;
    if (rd) begin
      p1 = cache_base + 16'(cache_idx + 1);
      cache_idx = cache_idx + 1;
    end
  end

  // Monitor: count strobes and score every USB write against the queue
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (!rst) begin
      if (rd) rd_cnt++;
      if (!usb_pktend_n) pk_cnt++;
      if (!usb_slwr_n) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got %h required no write", usb_data);
        end else begin
          exp_w = exp_q.pop_front();
          chk("usb_data", 32'(usb_data), 32'(exp_w));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    rd_cnt = 0;
    wr_cnt = 0;
    pk_cnt = 0;
  endtask

  task automatic start_block(input logic [15:0] base);
    cache_base = base;
    cache_idx  = 0;
    for (int i = 0; i < BLK; i++) exp_q.push_back(base + 16'(i + 1));
    switch = ~switch;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) timeout(name);
  endtask

  task automatic wait_wr(input int n, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (wr_cnt >= n) done = 1'b1;
    end
    if (!done) timeout(name);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"},      32'(rd),           32'd0);
    chk({tag, "_slwr_n"},  32'(usb_slwr_n),   32'd1);
    chk({tag, "_pktend"},  32'(usb_pktend_n), 32'd1);
    chk({tag, "_busy"},    32'(busy),         32'd0);
    chk({tag, "_overrun"}, 32'(overrun),      32'd0);
    chk({tag, "_data"},    32'(usb_data),     32'd0);
  endtask

  initial begin
    bit seen_busy, fell;
    rst = 1'b1; en = 1'b1; switch = 1'b0; usb_full_n = 1'b1;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    repeat (2) tick();

    // Single block: exact cycle timing from the switch toggle (cycle 0)
    clr_counts();
    start_block(16'h0000);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("t1_rd_c%0d", k),     32'(rd),           32'((k >= 2 && k <= 9) ? 1 : 0));
      chk($sformatf("t1_slwr_c%0d", k),   32'(usb_slwr_n),   32'((k >= 5 && k <= 12) ? 0 : 1));
      chk($sformatf("t1_busy_c%0d", k),   32'(busy),         32'((k >= 1 && k <= 13) ? 1 : 0));
      chk($sformatf("t1_pktend_c%0d", k), 32'(usb_pktend_n), 32'((PK_EXP == 1 && k == 13) ? 0 : 1));
    end
    tick();
    chk("t1_rd_cnt", 32'(rd_cnt), 32'(BLK));
    chk("t1_wr_cnt", 32'(wr_cnt), 32'(BLK));
    chk("t1_pk_cnt", 32'(pk_cnt), 32'(PK_EXP));

    // Backpressure: stall the USB side for 20 cycles once two words are out
    clr_counts();
    start_block(16'h0100);
    wait_wr(2, "bp_wait_wr2");
    usb_full_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("bp_outstanding_c%0d", k), 32'((rd_cnt - wr_cnt) <= SKD), 32'd1);
      if (k >= 10) chk($sformatf("bp_rd_stopped_c%0d", k), 32'(rd), 32'd0);
    end
    tick();
    usb_full_n = 1'b1;
    @(negedge clk);
    chk("bp_resume_same_cycle", 32'(usb_slwr_n), 32'd1);
    @(negedge clk);
    chk("bp_resume_next_cycle", 32'(usb_slwr_n), 32'd0);
    wait_idle("bp_idle");
    chk("bp_rd_cnt", 32'(rd_cnt), 32'(BLK));
    chk("bp_wr_cnt", 32'(wr_cnt), 32'(BLK));

    // en=0: an edge is ignored, and nothing is flagged
    clr_counts();
    en = 1'b0;
    switch = ~switch;
    repeat (10) tick();
    chk("en0_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("en0_busy", 32'(busy), 32'd0);
    chk("en0_overrun", 32'(overrun), 32'd0);
    en = 1'b1;
    start_block(16'h0180);
    wait_idle("en1_idle");
    chk("en1_rd_cnt", 32'(rd_cnt), 32'(BLK));
    chk("en1_wr_cnt", 32'(wr_cnt), 32'(BLK));

    // Back-to-back: second edge one cycle after busy falls
    clr_counts();
    start_block(16'h0200);
    seen_busy = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 400 && !fell; i++) begin
      tick();
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) fell = 1'b1;
    end
    if (!fell) timeout("b2b_busy_fall");
    tick();
    start_block(16'h0300);
    wait_idle("b2b_idle");
    chk("b2b_rd_cnt", 32'(rd_cnt), 32'(2 * BLK));
    chk("b2b_wr_cnt", 32'(wr_cnt), 32'(2 * BLK));
    chk("b2b_overrun", 32'(overrun), 32'd0);

    // Overrun: a late edge flags, does not abort, and is not queued
    clr_counts();
    start_block(16'h0400);
    repeat (3) tick();
    switch = ~switch;
    repeat (2) tick();
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_idle("ovr_idle");
    chk("ovr_rd_cnt", 32'(rd_cnt), 32'(BLK));
    chk("ovr_wr_cnt", 32'(wr_cnt), 32'(BLK));
    repeat (20) tick();
    chk("ovr_no_second_block", 32'(rd_cnt), 32'(BLK));
    chk("ovr_busy", 32'(busy), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-block while switch also toggles
    clr_counts();
    start_block(16'h0500);
    wait_wr(4, "mid_wait_wr4");
    rst = 1'b1;
    switch = ~switch;
    tick();
    chk_reset_vals("mid");
    exp_q.delete();
    tick();
    rst = 1'b0;
    clr_counts();
    repeat (20) tick();
    chk("mid_no_rd", 32'(rd_cnt), 32'd0);
    chk("mid_no_wr", 32'(wr_cnt), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);

    // Normal block after reset
    clr_counts();
    start_block(16'h0600);
    wait_idle("post_idle");
    chk("post_rd_cnt", 32'(rd_cnt), 32'(BLK));
    chk("post_wr_cnt", 32'(wr_cnt), 32'(BLK));
    chk("post_pk_cnt", 32'(pk_cnt), 32'(PK_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
